count_dir_decoder: RTL and testbench

COUNT_DIR_DECODER -- requirements
Module: count_dir_decoder

---
 rtl/count_dir_decoder.sv | 190 +++++++++++++++++++
 tb/tb_count_dir_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/count_dir_decoder.sv
// ---------------------------------------------------------------------------
// count_dir_decoder
//
// Purpose:
//   Watches a free-running 3-bit up/down counter and works out which way it
//   is counting. Each qualified sample is compared with the previous one:
//     - a difference of +1 (mod 8) is an up step,
//     - a difference of -1 (mod 8) is a down step,
//     - no difference is a hold,
//     - anything else is a jump (error).
//   The block only reports a direction after LOCK_CNT consecutive steps in
//   the same direction. While locked it keeps a signed position accumulator
//   that follows every step. A jump drops the lock and the block reacquires.
//
// Parameters:
//   LOCK_CNT   number of consecutive same-direction steps needed to lock
//              (legal range 1..7)
//   POS_W      width of the two's-complement position accumulator
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   count_in   observed counter value (3 bits)
//   sample_en  qualifies count_in on this cycle
//   pos_clr    synchronous clear of pos (wins over a coincident step)
//   dir_out    recovered direction, 1 = up, 0 = down
//   dir_valid  high while locked
//   step       one-cycle pulse per accepted step
//   err        one-cycle pulse per detected jump
//   pos        signed position, wraps modulo 2^POS_W
//   err_cnt    saturating count of jumps (stops at 15)
//
// All outputs are registered; a sample shows its effect one clock later.
// ---------------------------------------------------------------------------
module count_dir_decoder #(
  parameter int LOCK_CNT = 2,
  parameter int POS_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       count_in,
  input  logic             sample_en,
  input  logic             pos_clr,
  output logic             dir_out,
  output logic             dir_valid,
  output logic             step,
  output logic             err,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // The run counter never has to hold more than LOCK_CNT, which is at most 7.
  localparam logic [2:0] LockCntL = 3'(LOCK_CNT);

  state_t           r_state;
  logic [2:0]       r_prev;
  logic [2:0]       r_runCnt;
  logic             r_runDir;

  logic [2:0]       w_delta;
  logic             w_isHold;
  logic             w_isUp;
  logic             w_isDown;
  logic             w_isStep;
  logic             w_isJump;
  logic             w_stepDir;
  logic [2:0]       w_acqRunCnt;
  logic             w_acqLock;
  logic [POS_W-1:0] w_posStep;
  logic [3:0]       w_errCntInc;

  // Classify the current sample against the previous one. The 3-bit
  // subtraction wraps naturally, so 7->0 reads as +1 and 0->7 as -1.
  // Also precompute what the run counter becomes if this sample is a step
  // while acquiring: a step in the same direction (or the first step of a
  // run) extends the run, a reversal starts a new run of length one.
  always_comb begin
    w_delta     = count_in - r_prev;
    w_isHold    = (w_delta == 3'd0);
    w_isUp      = (w_delta == 3'd1);
    w_isDown    = (w_delta == 3'd7);
    w_isStep    = w_isUp | w_isDown;
    w_isJump    = ~(w_isHold | w_isStep);
    w_stepDir   = w_isUp;

    if ((r_runCnt == 3'd0) || (w_stepDir == r_runDir)) begin
      w_acqRunCnt = r_runCnt + 3'd1;
    end else begin
      w_acqRunCnt = 3'd1;
    end
    w_acqLock   = w_isStep && (w_acqRunCnt == LockCntL);

    if (w_stepDir) begin
      w_posStep = pos + POS_W'(1);
    end else begin
      w_posStep = pos - POS_W'(1);
    end

    if (err_cnt == 4'd15) begin
      w_errCntInc = err_cnt;
    end else begin
      w_errCntInc = err_cnt + 4'd1;
    end
  end

  // Main state machine with all outputs registered. step and err are
  // pulses, so they default low every cycle and are only raised by the
  // sample that causes them. pos_clr is applied after the state machine so
  // that it overrides any position update made by a coincident step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_prev    <= 3'd0;
      r_runCnt  <= 3'd0;
      r_runDir  <= 1'b0;
      dir_out   <= 1'b0;
      dir_valid <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      pos       <= '0;
      err_cnt   <= 4'd0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;

      if (sample_en) begin
        case (r_state)
          IDLE: begin
            r_prev   <= count_in;
            r_runCnt <= 3'd0;
            r_state  <= ACQ;
          end

          ACQ: begin
            r_prev <= count_in;
            if (w_isJump) begin
              err      <= 1'b1;
              err_cnt  <= w_errCntInc;
              r_runCnt <= 3'd0;
            end else if (w_isStep) begin
              r_runCnt <= w_acqRunCnt;
              r_runDir <= w_stepDir;
              // The step that completes the run is reported as a real step
              // and already moves the position.
              if (w_acqLock) begin
                r_state   <= LOCKED;
                dir_valid <= 1'b1;
                dir_out   <= w_stepDir;
                step      <= 1'b1;
                pos       <= w_posStep;
              end
            end
          end

          LOCKED: begin
            r_prev <= count_in;
            if (w_isJump) begin
              err       <= 1'b1;
              err_cnt   <= w_errCntInc;
              dir_valid <= 1'b0;
              r_runCnt  <= 3'd0;
              r_state   <= ACQ;
            end else if (w_isStep) begin
              // A reversal while locked just flips the direction.
              step     <= 1'b1;
              dir_out  <= w_stepDir;
              r_runDir <= w_stepDir;
              pos      <= w_posStep;
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end

      if (pos_clr) begin
        pos <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_dir_decoder.sv
// ---------------------------------------------------------------------------
// tb_count_dir_decoder
//
// Purpose:
//   Self-checking bench for count_dir_decoder with default parameters
//   (LOCK_CNT=2, POS_W=8). A table of directed vectors walks through lock,
//   reversal, wrap, jump/relock, holds and gaps; hand-written sequences then
//   cover error-count saturation, clear-vs-step, reset mid-lock and a
//   direction change while acquiring.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_count_dir_decoder;

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic [2:0]  cin;
    logic [15:0] exp;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count_in;
  logic       sample_en;
  logic       pos_clr;
  logic       dir_out;
  logic       dir_valid;
  logic       step;
  logic       err;
  logic [7:0] pos;
  logic [3:0] err_cnt;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  count_dir_decoder #(
    .LOCK_CNT (2),
    .POS_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .sample_en (sample_en),
    .pos_clr   (pos_clr),
    .dir_out   (dir_out),
    .dir_valid (dir_valid),
    .step      (step),
    .err       (err),
    .pos       (pos),
    .err_cnt   (err_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Packs an expected output set in the same order checkOutput reads it.
  function automatic logic [15:0] pk(input logic d, input logic v,
                                     input logic s, input logic e,
                                     input logic [7:0] p,
                                     input logic [3:0] ec);
    return {d, v, s, e, p, ec};
  endfunction

  // Drives one cycle of inputs, lets the clock edge take them, and returns
  // 1 time unit after the edge so outputs are settled for checking.
  task automatic applyStimulus(input logic r, input logic e, input logic c,
                               input logic [2:0] v);
    rst       = r;
    sample_en = e;
    pos_clr   = c;
    count_in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [15:0] exp);
    logic [15:0] act;
    act = {dir_out, dir_valid, step, err, pos, err_cnt};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got dir=%0b valid=%0b step=%0b err=%0b pos=%0d errcnt=%0d, want dir=%0b valid=%0b step=%0b err=%0b pos=%0d errcnt=%0d",
               nm, act[15], act[14], act[13], act[12], act[11:4], act[3:0],
               exp[15], exp[14], exp[13], exp[12], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic runStep(input logic r, input logic e, input logic c,
                         input logic [2:0] v, input string nm,
                         input logic [15:0] exp);
    applyStimulus(r, e, c, v);
    checkOutput(nm, exp);
  endtask

  task automatic addVec(input logic r, input logic e, input logic c,
                        input logic [2:0] v, input logic [15:0] exp,
                        input string nm);
    vec_t t;
    t.rst  = r;
    t.en   = e;
    t.clr  = c;
    t.cin  = v;
    t.exp  = exp;
    t.name = nm;
    vecs.push_back(t);
  endtask

  initial begin
    logic [2:0] v;
    logic [3:0] ec;

    rst       = 1'b1;
    sample_en = 1'b0;
    pos_clr   = 1'b0;
    count_in  = 3'd0;

    // Reset, and reset taking priority over a sample.
    addVec(1, 0, 0, 3'd0, pk(0, 0, 0, 0, 8'd0,   4'd0), "reset");
    addVec(1, 1, 1, 3'd3, pk(0, 0, 0, 0, 8'd0,   4'd0), "reset_prio");
    // Up lock: 5,6,7,0,1.
    addVec(0, 1, 0, 3'd5, pk(0, 0, 0, 0, 8'd0,   4'd0), "idle_load");
    addVec(0, 1, 0, 3'd6, pk(0, 0, 0, 0, 8'd0,   4'd0), "acq_run1");
    addVec(0, 1, 0, 3'd7, pk(1, 1, 1, 0, 8'd1,   4'd0), "up_lock");
    addVec(0, 1, 0, 3'd0, pk(1, 1, 1, 0, 8'd2,   4'd0), "up_wrap70");
    addVec(0, 1, 0, 3'd1, pk(1, 1, 1, 0, 8'd3,   4'd0), "up_pos3");
    // Reversal and 0->7 wrap while locked.
    addVec(0, 1, 0, 3'd0, pk(0, 1, 1, 0, 8'd2,   4'd0), "down_rev");
    addVec(0, 1, 0, 3'd7, pk(0, 1, 1, 0, 8'd1,   4'd0), "down_wrap07");
    addVec(0, 1, 0, 3'd6, pk(0, 1, 1, 0, 8'd0,   4'd0), "down_pos0");
    // Climb to prev=2, then jump to 5 and relock with 6,7.
    addVec(0, 1, 0, 3'd7, pk(1, 1, 1, 0, 8'd1,   4'd0), "up_again1");
    addVec(0, 1, 0, 3'd0, pk(1, 1, 1, 0, 8'd2,   4'd0), "up_again2");
    addVec(0, 1, 0, 3'd1, pk(1, 1, 1, 0, 8'd3,   4'd0), "up_again3");
    addVec(0, 1, 0, 3'd2, pk(1, 1, 1, 0, 8'd4,   4'd0), "up_again4");
    addVec(0, 1, 0, 3'd5, pk(1, 0, 0, 1, 8'd4,   4'd1), "jump");
    addVec(0, 1, 0, 3'd6, pk(1, 0, 0, 0, 8'd4,   4'd1), "reacq_run1");
    addVec(0, 1, 0, 3'd7, pk(1, 1, 1, 0, 8'd5,   4'd1), "relock");
    // Down to prev=4, then holds and gaps with garbage on count_in.
    addVec(0, 1, 0, 3'd6, pk(0, 1, 1, 0, 8'd4,   4'd1), "down_a");
    addVec(0, 1, 0, 3'd5, pk(0, 1, 1, 0, 8'd3,   4'd1), "down_b");
    addVec(0, 1, 0, 3'd4, pk(0, 1, 1, 0, 8'd2,   4'd1), "down_c");
    addVec(0, 1, 0, 3'd4, pk(0, 1, 0, 0, 8'd2,   4'd1), "hold1");
    addVec(0, 0, 0, 3'd1, pk(0, 1, 0, 0, 8'd2,   4'd1), "gap1");
    addVec(0, 1, 0, 3'd4, pk(0, 1, 0, 0, 8'd2,   4'd1), "hold2");
    addVec(0, 0, 0, 3'd7, pk(0, 1, 0, 0, 8'd2,   4'd1), "gap2");
    // Position going negative and back.
    addVec(0, 1, 0, 3'd3, pk(0, 1, 1, 0, 8'd1,   4'd1), "neg_a");
    addVec(0, 1, 0, 3'd2, pk(0, 1, 1, 0, 8'd0,   4'd1), "neg_b");
    addVec(0, 1, 0, 3'd1, pk(0, 1, 1, 0, 8'd255, 4'd1), "neg_wrap");
    addVec(0, 1, 0, 3'd2, pk(1, 1, 1, 0, 8'd0,   4'd1), "neg_back");

    foreach (vecs[i]) begin
      runStep(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].cin,
              vecs[i].name, vecs[i].exp);
    end

    // 17 jumps of +4 from prev=2: err_cnt climbs from 1 and sticks at 15.
    v = 3'd2;
    for (int k = 1; k <= 17; k++) begin
      v  = v + 3'd4;
      ec = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      runStep(0, 1, 0, v, "jump_sat", pk(1, 0, 0, 1, 8'd0, ec));
    end

    // Relock from prev=6, count up to pos=10, then clear together with a step.
    runStep(0, 1, 0, 3'd7, "sat_run1", pk(1, 0, 0, 0, 8'd0, 4'd15));
    runStep(0, 1, 0, 3'd0, "sat_lock", pk(1, 1, 1, 0, 8'd1, 4'd15));
    v = 3'd0;
    for (int k = 2; k <= 10; k++) begin
      v = v + 3'd1;
      runStep(0, 1, 0, v, "climb", pk(1, 1, 1, 0, 8'(k), 4'd15));
    end
    runStep(0, 1, 1, 3'd2, "clr_step",  pk(1, 1, 1, 0, 8'd0, 4'd15));
    runStep(0, 1, 0, 3'd3, "after_clr", pk(1, 1, 1, 0, 8'd1, 4'd15));
    runStep(0, 0, 1, 3'd5, "clr_only",  pk(1, 1, 0, 0, 8'd0, 4'd15));

    // Climb to pos=7, reset mid-lock, then relock with 3,4,5.
    v = 3'd3;
    for (int k = 1; k <= 7; k++) begin
      v = v + 3'd1;
      runStep(0, 1, 0, v, "pre_rst", pk(1, 1, 1, 0, 8'(k), 4'd15));
    end
    runStep(1, 1, 0, 3'd3, "rst_midlock", pk(0, 0, 0, 0, 8'd0, 4'd0));
    runStep(0, 1, 0, 3'd3, "post_load",   pk(0, 0, 0, 0, 8'd0, 4'd0));
    runStep(0, 1, 0, 3'd4, "post_run1",   pk(0, 0, 0, 0, 8'd0, 4'd0));
    runStep(0, 1, 0, 3'd5, "post_lock",   pk(1, 1, 1, 0, 8'd1, 4'd0));

    // Reversal while acquiring restarts the run; lock lands on a down step.
    runStep(1, 0, 0, 3'd0, "rst2",        pk(0, 0, 0, 0, 8'd0,   4'd0));
    runStep(0, 1, 0, 3'd3, "rev_load",    pk(0, 0, 0, 0, 8'd0,   4'd0));
    runStep(0, 1, 0, 3'd4, "rev_up1",     pk(0, 0, 0, 0, 8'd0,   4'd0));
    runStep(0, 1, 0, 3'd3, "rev_down1",   pk(0, 0, 0, 0, 8'd0,   4'd0));
    runStep(0, 1, 0, 3'd3, "rev_hold",    pk(0, 0, 0, 0, 8'd0,   4'd0));
    runStep(0, 1, 0, 3'd2, "rev_lock",    pk(0, 1, 1, 0, 8'd255, 4'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
